mem_arbiter: RTL and testbench

- Shares the single unified main memory between the instruction cache (fetch-stage miss) and the data cache (MEM-stage miss or write-through store).
- Grants one requester at a time and issues a block fill as WORDS_PER_BLOCK consecutive word addresses.
- Counts the words the memory returns, then steers each one to the granted cache's fill port with its address.
- Drives per-requester stall and done signals back to the pipeline.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_fill_counter.sv | 34 +++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: arbiter state encoding and block geometry shared with the cache interface.
package mem_arbiter_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_OFF_BITS  = $clog2(2 * WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2,
        WRITE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// mem_arbiter_fill_counter: issue and receive word counters for one block fill, with last-word detection.
module mem_arbiter_fill_counter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             issue,
    input  logic             recv,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] recv_cnt,
    output logic             issue_more,
    output logic             last_recv
);

    assign issue_more = issue_cnt < CNT_W'(WORDS_PER_BLOCK);
    assign last_recv  = recv & (recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

    // word 0 is issued on the grant edge itself, so a fresh fill starts with one word already out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (start) begin
            issue_cnt <= CNT_W'(1);
            recv_cnt  <= '0;
        end else begin
            if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
            if (recv) recv_cnt <= recv_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares main memory between the I- and D-cache, issuing block fills and single-word stores.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate contested fill grants instead of fixed D-over-I priority.
module mem_arbiter #(
    parameter int WORDS_PER_BLOCK = mem_arbiter_pkg::WORDS_PER_BLOCK,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_req,
    input  logic              dcache_wr,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_wdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_data_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              icache_fill_we,
    output logic              dcache_fill_we,
    output logic              icache_stall,
    output logic              dcache_stall,
    output logic              icache_done,
    output logic              dcache_done
);

    import mem_arbiter_pkg::*;

    localparam int CNT_W    = $clog2(WORDS_PER_BLOCK) + 1;
    localparam int OFF_BITS = $clog2(2 * WORDS_PER_BLOCK);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_BITS) - 1);

    arb_state_e        state, state_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic [CNT_W-1:0]  issue_cnt, recv_cnt;
    logic              issue_more, last_recv;
    logic              filling, start, issue, recv, wr_go;
    logic              d_store, d_fill, i_fill, pick_d;

    // a requester whose done is pulsing still holds req this cycle and must not be granted again
    assign icache_stall = icache_req & ~icache_done;
    assign dcache_stall = dcache_req & ~dcache_done;
    assign d_store      = dcache_stall & dcache_wr;
    assign d_fill       = dcache_stall & ~dcache_wr;
    assign i_fill       = icache_stall;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;
    assign pick_d = d_fill & (~i_fill | ~last_d);
    // only a contested fill grant moves the turn
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_d <= 1'b0;
        else if (start & d_fill & i_fill) last_d <= pick_d;
    end
`else
    assign pick_d = d_fill;
`endif

    assign filling = (state == FILL_I) | (state == FILL_D);
    assign recv    = filling & mem_data_valid;
    assign issue   = filling & issue_more;
    assign start   = (state == IDLE) & ~d_store & (pick_d | i_fill);
    assign wr_go   = (state == IDLE) & d_store;
    assign base_nx = (pick_d ? dcache_addr : icache_addr) & BASE_MASK;

    mem_arbiter_fill_counter #(
        .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
        .CNT_W          (CNT_W)
    ) u_fill_counter (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .issue     (issue),
        .recv      (recv),
        .issue_cnt (issue_cnt),
        .recv_cnt  (recv_cnt),
        .issue_more(issue_more),
        .last_recv (last_recv)
    );

    always_comb begin
        state_nx       = state;
        fill_data      = recv ? mem_data_in : '0;
        fill_addr      = recv ? base + (ADDR_W'(recv_cnt) << 1) : '0;
        icache_fill_we = recv & (state == FILL_I);
        dcache_fill_we = recv & (state == FILL_D);
        case (state)
            IDLE:    state_nx = d_store ? WRITE : pick_d ? FILL_D : i_fill ? FILL_I : IDLE;
            WRITE:   state_nx = IDLE;
            default: state_nx = last_recv ? IDLE : state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            base        <= '0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            icache_done <= 1'b0;
            dcache_done <= 1'b0;
        end else begin
            state       <= state_nx;
            base        <= start ? base_nx : base;
            mem_enable  <= start | issue | wr_go;
            mem_wr      <= wr_go;
            mem_addr    <= start ? base_nx : wr_go ? dcache_addr :
                           issue ? base + (ADDR_W'(issue_cnt) << 1) : mem_addr;
            mem_wdata   <= wr_go ? dcache_wdata : mem_wdata;
            icache_done <= (state == FILL_I) & last_recv;
            dcache_done <= ((state == FILL_D) & last_recv) | wr_go;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random request rounds against a queue-based model of arbitration order and a latency memory.
module tb_mem_arbiter;

    localparam int WPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        icache_req = 1'b0, dcache_req = 1'b0, dcache_wr = 1'b0;
    logic [15:0] icache_addr = '0, dcache_addr = '0, dcache_wdata = '0;
    logic        mem_enable, mem_wr, mem_data_valid;
    logic [15:0] mem_addr, mem_wdata, mem_data_in, fill_data, fill_addr;
    logic        icache_fill_we, dcache_fill_we, icache_stall, dcache_stall, icache_done, dcache_done;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
        .fill_data(fill_data), .fill_addr(fill_addr),
        .icache_fill_we(icache_fill_we), .dcache_fill_we(dcache_fill_we),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .icache_done(icache_done), .dcache_done(dcache_done)
    );

    typedef struct { logic [15:0] addr; logic wr; logic [15:0] wdata; int gap; } mem_op_t;
    typedef struct { logic d; logic store; } done_t;
    typedef struct { logic [15:0] a; int t; } rd_t;

    mem_op_t     exp_mem[$];
    logic [15:0] exp_if[$], exp_df[$];
    done_t       exp_done[$];
    rd_t         rdq[$];

    int cyc = 0, last_t = 0, lat_min = 1, lat_max = 5;
    int checks = 0, errors = 0;
    int last_done_cyc = -100, last_fill_i = -100, last_fill_d = -100, fills_i = 0;
    bit spur_on = 1'b0, rr_last_d = 1'b0;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] val);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event with value %0h, nothing expected (cycle %0d)", name, val, cyc);
    endtask

    // memory: in-order reads, each returned a random number of cycles after its issue
    initial begin
        rd_t r;
        mem_data_valid = 1'b0;
        mem_data_in    = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            mem_data_valid = 1'b0;
            mem_data_in    = 16'($urandom);
            if (!rst) rdq.delete();
            else if (spur_on) mem_data_valid = 1'b1;
            else if (rdq.size() > 0 && rdq[0].t <= cyc) begin
                r = rdq.pop_front();
                mem_data_valid = 1'b1;
                mem_data_in    = mdata(r.a);
            end
        end
    end

    always @(negedge clk) begin : monitor
        mem_op_t     op;
        done_t       e;
        int          t;
        logic [15:0] ea;
        if (rst) begin
            check("icache_stall", icache_stall, icache_done ? 1'b0 : icache_req);
            check("dcache_stall", dcache_stall, dcache_done ? 1'b0 : dcache_req);
            check("fill_we_exclusive", icache_fill_we & dcache_fill_we, 0);
            if (mem_enable) begin
                if (exp_mem.size() == 0) unexpected("mem_access", mem_addr);
                else begin
                    op = exp_mem.pop_front();
                    check("mem_addr", mem_addr, op.addr);
                    check("mem_wr", mem_wr, op.wr);
                    if (op.wr) check("mem_wdata", mem_wdata, op.wdata);
                    if (op.gap > 0) check("grant_gap", cyc - last_done_cyc, op.gap);
                end
                if (!mem_wr) begin
                    t = cyc + int'($urandom_range(lat_max, lat_min));
                    if (t <= last_t) t = last_t + 1;
                    last_t = t;
                    rdq.push_back('{mem_addr, t});
                end
            end
            if (icache_fill_we) begin
                fills_i++;
                last_fill_i = cyc;
                if (exp_if.size() == 0) unexpected("icache_fill", fill_addr);
                else begin
                    ea = exp_if.pop_front();
                    check("i_fill_addr", fill_addr, ea);
                    check("i_fill_data", fill_data, mdata(ea));
                end
            end
            if (dcache_fill_we) begin
                last_fill_d = cyc;
                if (exp_df.size() == 0) unexpected("dcache_fill", fill_addr);
                else begin
                    ea = exp_df.pop_front();
                    check("d_fill_addr", fill_addr, ea);
                    check("d_fill_data", fill_data, mdata(ea));
                end
            end
            if (icache_done) begin
                if (exp_done.size() == 0) unexpected("icache_done", 1);
                else begin
                    e = exp_done.pop_front();
                    check("i_done_side", e.d, 0);
                    check("i_done_timing", cyc - last_fill_i, 1);
                    check("i_fills_left", exp_if.size(), 0);
                end
                last_done_cyc = cyc;
            end
            if (dcache_done) begin
                if (exp_done.size() == 0) unexpected("dcache_done", 1);
                else begin
                    e = exp_done.pop_front();
                    check("d_done_side", e.d, 1);
                    if (e.store) check("store_done_with_write", mem_enable & mem_wr, 1);
                    else begin
                        check("d_done_timing", cyc - last_fill_d, 1);
                        check("d_fills_left", exp_df.size(), 0);
                    end
                end
                last_done_cyc = cyc;
            end
        end
    end

    task automatic push_fill(input bit d, input logic [15:0] a, input int gap);
        mem_op_t op;
        done_t   e;
        for (int k = 0; k < WPB; k++) begin
            op.addr  = (a & 16'hFFF0) + 16'(2 * k);
            op.wr    = 1'b0;
            op.wdata = '0;
            op.gap   = (k == 0) ? gap : 0;
            exp_mem.push_back(op);
            if (d) exp_df.push_back(op.addr);
            else exp_if.push_back(op.addr);
        end
        e.d = d;
        e.store = 1'b0;
        exp_done.push_back(e);
    endtask

    task automatic push_store(input logic [15:0] a, input logic [15:0] w, input int gap);
        mem_op_t op;
        done_t   e;
        op.addr = a; op.wr = 1'b1; op.wdata = w; op.gap = gap;
        exp_mem.push_back(op);
        e.d = 1'b1;
        e.store = 1'b1;
        exp_done.push_back(e);
    endtask

    task automatic flush();
        exp_mem.delete(); exp_if.delete(); exp_df.delete(); exp_done.delete();
    endtask

    // kind: 0 I fill, 1 D fill, 2 D store, 3 I+D fill together, 4 I fill + D store together,
    //       5 I fill then D store later, 6 I fill then D fill later
    task automatic round(input int kind, input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd);
        bit first_d, drop_i, drop_d, early_drop;
        int c;
        case (kind)
            0: push_fill(0, ia, 0);
            1: push_fill(1, da, 0);
            2: push_store(da, wd, 0);
            3: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                first_d = !rr_last_d;
                rr_last_d = first_d;
`else
                first_d = 1'b1;
`endif
                if (first_d) begin push_fill(1, da, 0); push_fill(0, ia, 1); end
                else begin push_fill(0, ia, 0); push_fill(1, da, 1); end
            end
            4: begin push_store(da, wd, 0); push_fill(0, ia, 2); end
            5: begin push_fill(0, ia, 0); push_store(da, wd, 1); end
            default: begin push_fill(0, ia, 0); push_fill(1, da, 1); end
        endcase
        @(posedge clk); #1;
        icache_addr  = ia;
        dcache_addr  = da;
        dcache_wdata = wd;
        dcache_wr    = (kind == 2 || kind == 4 || kind == 5);
        icache_req   = (kind != 1 && kind != 2);
        dcache_req   = (kind != 0 && kind < 5);
        early_drop   = (kind == 0) && ($urandom_range(3, 0) == 0);
        for (c = 0; c < 400 && (exp_done.size() > 0 || icache_req || dcache_req); c++) begin
            @(negedge clk);
            drop_i = icache_done;
            drop_d = dcache_done;
            @(posedge clk); #1;
            if (drop_i || (early_drop && c == 2)) icache_req = 1'b0;
            if (drop_d) dcache_req = 1'b0;
            if (kind >= 5 && c == 2) dcache_req = 1'b1;
        end
        if (exp_done.size() > 0) begin
            unexpected("round_timeout", kind);
            icache_req = 1'b0;
            dcache_req = 1'b0;
            flush();
        end
        check("leftover_ops", exp_mem.size() + exp_if.size() + exp_df.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_enable", mem_enable, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_fill_data", fill_data, 0);
        check("rst_fill_addr", fill_addr, 0);
        check("rst_fill_we", {icache_fill_we, dcache_fill_we}, 0);
        check("rst_done", {icache_done, dcache_done}, 0);
        check("rst_stalls_idle", {icache_stall, dcache_stall}, 0);
        icache_req = 1'b1;
        dcache_req = 1'b1;
        #1;
        check("rst_stalls_req", {icache_stall, dcache_stall}, 2'b11);
        icache_req = 1'b0;
        dcache_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        // stray valid while idle must be dropped
        @(negedge clk); spur_on = 1'b1;
        @(negedge clk); check("idle_valid_fill_we", {icache_fill_we, dcache_fill_we}, 0);
        @(negedge clk); check("idle_valid_fill_we", {icache_fill_we, dcache_fill_we}, 0);
        spur_on = 1'b0;
        lat_min = 4; lat_max = 4;
        round(0, 16'h1236, 16'h0000, 16'h0000);
        lat_min = 1; lat_max = 5;
        round(3, 16'h2000, 16'h0040, 16'h0000);
        round(3, 16'h2222, 16'h4444, 16'h0000);
        round(2, 16'h0000, 16'h00A2, 16'hBEEF);
        round(5, 16'h1236, 16'h00A2, 16'hBEEF);
        round(4, 16'h5678, 16'h0102, 16'h1357);
        // reset in the middle of a fill
        lat_min = 1; lat_max = 3;
        push_fill(0, 16'h3A5C, 0);
        @(posedge clk); #1;
        icache_addr = 16'h3A5C;
        icache_req  = 1'b1;
        f0 = fills_i;
        for (int c = 0; c < 100 && fills_i < f0 + 3; c++) @(negedge clk);
        check("reset_fill_progress", fills_i - f0, 3);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("midrst_fill_we", {icache_fill_we, dcache_fill_we}, 0);
        check("midrst_mem_enable", mem_enable, 0);
        check("midrst_done", {icache_done, dcache_done}, 0);
        icache_req = 1'b0;
        flush();
        rr_last_d = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        lat_min = 1; lat_max = 5;
        round(0, 16'h3A5C, 16'h0000, 16'h0000);
        for (int n = 0; n < 40; n++)
            round(int'($urandom_range(6, 0)), 16'($urandom), 16'($urandom), 16'($urandom));
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
